// File: rtl/pwm_multi.sv
// Multi-channel PWM generator with staged/active config, finite bursts and continuous mode.
// Optional per-channel output polarity is enabled by defining PWM_MULTI_POLARITY_EN.
module pwm_multi #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned TIMES_W  = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [CHANNELS-1:0]         i_en,
    input  logic [CHANNELS-1:0]         i_load,
    input  logic [CHANNELS*CNT_W-1:0]   i_period,
    input  logic [CHANNELS*CNT_W-1:0]   i_high,
    input  logic [CHANNELS*TIMES_W-1:0] i_times,
`ifdef PWM_MULTI_POLARITY_EN
    input  logic [CHANNELS-1:0]         i_pol,
`endif
    output logic [CHANNELS-1:0]         o_pwm,
    output logic [CHANNELS-1:0]         o_busy,
    output logic [CHANNELS-1:0]         o_done
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        state_t               r_state;
        logic [CNT_W-1:0]     r_st_period, r_st_high, r_act_period, r_act_high, r_cnt;
        logic [TIMES_W-1:0]   r_st_times, r_act_times, r_pulses;
        logic                 r_st_pol, r_act_pol, r_pwm, r_done;

        logic [CNT_W-1:0]     w_in_period, w_in_high, w_cm_period, w_cm_high, w_cnt_inc;
        logic [TIMES_W-1:0]   w_in_times, w_cm_times, w_pulses_inc;
        logic                 w_in_pol, w_cm_pol, w_wrap, w_last;

        assign w_in_period = i_period[g*CNT_W +: CNT_W];
        assign w_in_high   = i_high[g*CNT_W +: CNT_W];
        assign w_in_times  = i_times[g*TIMES_W +: TIMES_W];
`ifdef PWM_MULTI_POLARITY_EN
        assign w_in_pol    = i_pol[g];
`else
        assign w_in_pol    = 1'b0;
`endif

        // A load landing on the wrap edge bypasses the staging registers.
        assign w_cm_period = i_load[g] ? w_in_period : r_st_period;
        assign w_cm_high   = i_load[g] ? w_in_high   : r_st_high;
        assign w_cm_times  = i_load[g] ? w_in_times  : r_st_times;
        assign w_cm_pol    = i_load[g] ? w_in_pol    : r_st_pol;

        assign w_cnt_inc    = r_cnt + CNT_W'(1);
        assign w_pulses_inc = r_pulses + TIMES_W'(1);
        assign w_wrap       = (r_cnt == r_act_period - CNT_W'(1));
        assign w_last       = (r_act_times != '0) && (w_pulses_inc == r_act_times);

        always_ff @(posedge clk) begin
            if (rst) begin
                r_state      <= StIdle;
                r_st_period  <= '0;
                r_st_high    <= '0;
                r_st_times   <= '0;
                r_st_pol     <= 1'b0;
                r_act_period <= '0;
                r_act_high   <= '0;
                r_act_times  <= '0;
                r_act_pol    <= 1'b0;
                r_cnt        <= '0;
                r_pulses     <= '0;
                r_pwm        <= 1'b0;
                r_done       <= 1'b0;
            end else begin
                r_done <= 1'b0;
                if (i_load[g]) begin
                    r_st_period <= w_in_period;
                    r_st_high   <= w_in_high;
                    r_st_times  <= w_in_times;
                    r_st_pol    <= w_in_pol;
                end
                case (r_state)
                    StIdle: begin
                        r_cnt    <= '0;
                        r_pulses <= '0;
                        r_pwm    <= 1'b0;
                        if (i_en[g] && (r_act_period != '0)) begin
                            r_state <= StRun;
                            r_pwm   <= (r_act_high != '0);
                        end else begin
                            r_act_period <= r_st_period;
                            r_act_high   <= r_st_high;
                            r_act_times  <= r_st_times;
                            r_act_pol    <= r_st_pol;
                        end
                    end
                    StRun: begin
                        if (!i_en[g]) begin
                            r_state  <= StIdle;
                            r_pwm    <= 1'b0;
                            r_cnt    <= '0;
                            r_pulses <= '0;
                        end else if (w_wrap) begin
                            r_cnt        <= '0;
                            r_pulses     <= w_pulses_inc;
                            r_act_period <= w_cm_period;
                            r_act_high   <= w_cm_high;
                            r_act_times  <= w_cm_times;
                            r_act_pol    <= w_cm_pol;
                            if (w_last) begin
                                r_state <= StDone;
                                r_pwm   <= 1'b0;
                                r_done  <= 1'b1;
                            end else if (w_cm_period == '0) begin
                                r_state  <= StIdle;
                                r_pwm    <= 1'b0;
                                r_pulses <= '0;
                            end else begin
                                r_pwm <= (w_cm_high != '0);
                            end
                        end else begin
                            r_cnt <= w_cnt_inc;
                            r_pwm <= (w_cnt_inc < r_act_high);
                        end
                    end
                    StDone: begin
                        r_pwm <= 1'b0;
                        if (!i_en[g]) begin
                            r_state  <= StIdle;
                            r_pulses <= '0;
                        end
                    end
                    default: r_state <= StIdle;
                endcase
            end
        end

        assign o_pwm[g]  = r_pwm ^ r_act_pol;
        assign o_busy[g] = (r_state == StRun);
        assign o_done[g] = r_done;
    end

endmodule

// File: tb/tb_pwm_multi.sv
// Self-checking bench for pwm_multi: per-scenario tasks against an arithmetic waveform model.
// Define PWM_MULTI_POLARITY_EN to also exercise the polarity option.
module tb_pwm_multi;

    localparam int NCH = 4;
    localparam int CW  = 32;
    localparam int TW  = 16;

    logic                clk = 1'b0;
    logic                rst;
    logic [NCH-1:0]      en, load;
    logic [NCH*CW-1:0]   period, high;
    logic [NCH*TW-1:0]   times;
    logic [NCH-1:0]      pwm, busy, done;
`ifdef PWM_MULTI_POLARITY_EN
    logic [NCH-1:0]      pol;
`endif

    int total = 0;
    int bad   = 0;

    pwm_multi #(.CHANNELS(NCH), .CNT_W(CW), .TIMES_W(TW)) dut (
        .clk      (clk),
        .rst      (rst),
        .i_en     (en),
        .i_load   (load),
        .i_period (period),
        .i_high   (high),
        .i_times  (times),
`ifdef PWM_MULTI_POLARITY_EN
        .i_pol    (pol),
`endif
        .o_pwm    (pwm),
        .o_busy   (busy),
        .o_done   (done)
    );

    always #5 clk = ~clk;

    // Expected {done, busy, pwm} j cycles after the enable edge of a burst (t==0: endless).
    function automatic logic [2:0] model(int p, int h, int t, int j);
        if (t != 0 && j >= p * t) return {(j == p * t), 2'b00};
        return {1'b0, 1'b1, ((j % p) < h)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int c, input int p, input int h, input int t);
        period[c*CW +: CW] = CW'(p);
        high[c*CW +: CW]   = CW'(h);
        times[c*TW +: TW]  = TW'(t);
    endtask

    // Load a config while idle and let it reach the active registers.
    task automatic load_idle(input logic [NCH-1:0] mask);
        load = mask;
        tick();
        load = '0;
        tick();
    endtask

    task automatic stop_all();
        en = '0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        logic [NCH-1:0] exp0 = '0;
        en = '1; load = '1;
        for (int c = 0; c < NCH; c++) set_cfg(c, 4, 2, 1);
        rst = 1'b1;
        tick();
        tick();
        total++; if (pwm !== exp0)  begin bad++; $display("FAIL reset_pwm got=%b want=%b", pwm, exp0); end
        total++; if (busy !== exp0) begin bad++; $display("FAIL reset_busy got=%b want=%b", busy, exp0); end
        total++; if (done !== exp0) begin bad++; $display("FAIL reset_done got=%b want=%b", done, exp0); end
        en = '0; load = '0;
        rst = 1'b0;
        tick();
        total++; if (busy !== exp0) begin bad++; $display("FAIL reset_idle got=%b want=%b", busy, exp0); end
    endtask

    task automatic test_burst();
        logic [2:0] obs, exp;
        set_cfg(0, 8, 5, 3);
        load_idle(4'b0001);
        en[0] = 1'b1;
        tick();
        for (int j = 0; j < 30; j++) begin
            obs = {done[0], busy[0], pwm[0]};
            exp = model(8, 5, 3, j);
            total++;
            if (obs !== exp) begin
                bad++; $display("FAIL burst j=%0d got=%b want=%b", j, obs, exp);
            end
            tick();
        end
        stop_all();
    endtask

    task automatic test_continuous();
        logic [2:0] obs, exp;
        set_cfg(1, 100, 40, 0);
        load_idle(4'b0010);
        en[1] = 1'b1;
        tick();
        for (int j = 0; j < 1000; j++) begin
            obs = {done[1], busy[1], pwm[1]};
            exp = model(100, 40, 0, j);
            total++;
            if (obs !== exp) begin
                bad++; $display("FAIL continuous j=%0d got=%b want=%b", j, obs, exp);
            end
            tick();
        end
        stop_all();
    endtask

    task automatic test_reload();
        logic [2:0] obs, exp;
        set_cfg(0, 8, 5, 0);
        load_idle(4'b0001);
        en[0] = 1'b1;
        tick();
        for (int j = 0; j < 42; j++) begin
            if (j < 8)       exp = model(8, 5, 0, j);
            else if (j < 18) exp = model(10, 2, 0, j - 8);
            else             exp = model(6, 1, 0, j - 18);
            obs = {done[0], busy[0], pwm[0]};
            total++;
            if (obs !== exp) begin
                bad++; $display("FAIL reload j=%0d got=%b want=%b", j, obs, exp);
            end
            // j==3: mid-period load; j==17: load coinciding with the wrap edge.
            if (j == 3) begin
                set_cfg(0, 10, 2, 0); load[0] = 1'b1;
            end else if (j == 17) begin
                set_cfg(0, 6, 1, 0); load[0] = 1'b1;
            end else begin
                load[0] = 1'b0;
            end
            tick();
        end
        load = '0;
        stop_all();
    endtask

    task automatic test_disable();
        logic [2:0] obs, exp;
        set_cfg(2, 8, 3, 10);
        load_idle(4'b0100);
        en[2] = 1'b1;
        tick();
        for (int j = 0; j < 90; j++) begin
            exp = (j < 50) ? model(8, 3, 10, j) : 3'b000;
            obs = {done[2], busy[2], pwm[2]};
            total++;
            if (obs !== exp) begin
                bad++; $display("FAIL disable j=%0d got=%b want=%b", j, obs, exp);
            end
            if (j == 49) en[2] = 1'b0;
            tick();
        end
        en[2] = 1'b1;
        tick();
        for (int j = 0; j < 16; j++) begin
            obs = {done[2], busy[2], pwm[2]};
            exp = model(8, 3, 10, j);
            total++;
            if (obs !== exp) begin
                bad++; $display("FAIL restart j=%0d got=%b want=%b", j, obs, exp);
            end
            tick();
        end
        stop_all();
    endtask

    task automatic test_boundaries();
        logic [2:0] obs, exp;
        int bp[3] = '{5, 8, 0};
        int bh[3] = '{0, 12, 3};
        int bt[3] = '{2, 1, 1};
        for (int k = 0; k < 3; k++) begin
            set_cfg(3, bp[k], bh[k], bt[k]);
            load_idle(4'b1000);
            en[3] = 1'b1;
            tick();
            for (int j = 0; j < 14; j++) begin
                obs = {done[3], busy[3], pwm[3]};
                exp = (bp[k] == 0) ? 3'b000 : model(bp[k], bh[k], bt[k], j);
                total++;
                if (obs !== exp) begin
                    bad++; $display("FAIL bound%0d j=%0d got=%b want=%b", k, j, obs, exp);
                end
                tick();
            end
            stop_all();
        end
        // Period 0 committed at a wrap drops the channel to idle without a done pulse.
        set_cfg(3, 4, 2, 0);
        load_idle(4'b1000);
        en[3] = 1'b1;
        tick();
        for (int j = 0; j < 12; j++) begin
            obs = {done[3], busy[3], pwm[3]};
            exp = (j < 4) ? model(4, 2, 0, j) : 3'b000;
            total++;
            if (obs !== exp) begin
                bad++; $display("FAIL period0 j=%0d got=%b want=%b", j, obs, exp);
            end
            if (j == 1) begin
                set_cfg(3, 0, 2, 0); load[3] = 1'b1;
            end else begin
                load[3] = 1'b0;
            end
            tick();
        end
        stop_all();
    endtask

    task automatic test_random_parallel();
        int p[NCH], h[NCH], t[NCH];
        logic [2:0] obs, exp;
        for (int it = 0; it < 6; it++) begin
            for (int c = 0; c < NCH; c++) begin
                p[c] = int'($urandom_range(1, 20));
                h[c] = int'($urandom_range(0, 24));
                t[c] = int'($urandom_range(0, 4));
                set_cfg(c, p[c], h[c], t[c]);
            end
            load_idle('1);
            en = '1;
            tick();
            for (int j = 0; j < 90; j++) begin
                for (int c = 0; c < NCH; c++) begin
                    obs = {done[c], busy[c], pwm[c]};
                    exp = model(p[c], h[c], t[c], j);
                    total++;
                    if (obs !== exp) begin
                        bad++;
                        $display("FAIL random it=%0d ch%0d p=%0d h=%0d t=%0d j=%0d got=%b want=%b",
                                 it, c, p[c], h[c], t[c], j, obs, exp);
                    end
                end
                tick();
            end
            stop_all();
        end
    endtask

    task automatic test_reset_mid();
        logic [2:0] obs;
        set_cfg(0, 8, 5, 2);
        load_idle(4'b0001);
        en[0] = 1'b1;
        tick();
        for (int j = 0; j < 5; j++) tick();
        rst = 1'b1; load = '1;
        tick();
        rst = 1'b0; load = '0;
        for (int j = 0; j < 20; j++) begin
            obs = {done[0], busy[0], pwm[0]};
            total++;
            if (obs !== 3'b000) begin
                bad++; $display("FAIL reset_mid j=%0d got=%b want=000", j, obs);
            end
            tick();
        end
        stop_all();
    endtask

`ifdef PWM_MULTI_POLARITY_EN
    task automatic test_polarity();
        logic [2:0] obs, exp;
        set_cfg(0, 8, 5, 1);
        pol[0] = 1'b1;
        load_idle(4'b0001);
        total++;
        if (pwm[0] !== 1'b1) begin bad++; $display("FAIL pol_idle got=%b want=1", pwm[0]); end
        en[0] = 1'b1;
        tick();
        for (int j = 0; j < 12; j++) begin
            exp = model(8, 5, 1, j);
            exp[0] = ~exp[0];
            obs = {done[0], busy[0], pwm[0]};
            total++;
            if (obs !== exp) begin
                bad++; $display("FAIL polarity j=%0d got=%b want=%b", j, obs, exp);
            end
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        pol = '0;
        total++;
        if (pwm !== 4'b0000) begin bad++; $display("FAIL pol_reset got=%b want=0000", pwm); end
        stop_all();
    endtask
`endif

    initial begin
        rst = 1'b1; en = '0; load = '0; period = '0; high = '0; times = '0;
`ifdef PWM_MULTI_POLARITY_EN
        pol = '0;
`endif
        test_reset();
        test_burst();
        test_continuous();
        test_reload();
        test_disable();
        test_boundaries();
        test_random_parallel();
        test_reset_mid();
`ifdef PWM_MULTI_POLARITY_EN
        test_polarity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pwm_multi.md
PWM_MULTI -- requirements
Module: pwm_multi

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, number of independent PWM channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 32, width of period/high fields.
REQ-003 SHALL have parameter TIMES_W, default 16, width of pulse-count field.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 i_en  in  CHANNELS  per-channel enable, level.
REQ-007 i_load  in  CHANNELS  per-channel config strobe; 1-cycle pulse captures the channel's fields.
REQ-008 i_period  in  CHANNELS*CNT_W  period in clk cycles; channel n at bits [n*CNT_W +: CNT_W].
REQ-009 i_high  in  CHANNELS*CNT_W  high time in clk cycles, same packing.
REQ-010 i_times  in  CHANNELS*TIMES_W  number of periods to emit; 0 = continuous.
REQ-011 o_pwm  out  CHANNELS  registered PWM outputs.
REQ-012 o_busy  out  CHANNELS  1 while channel in RUN.
REQ-013 o_done  out  CHANNELS  1-cycle pulse when a finite burst completes.

Function
REQ-014 Each channel SHALL hold a staged config (captured on i_load) and an active config (used by the counter).
REQ-015 Per-channel FSM states SHALL be IDLE, RUN, DONE.
REQ-016 IDLE: staged config copied to active every cycle; o_pwm=0; counters held at 0.
REQ-017 IDLE->RUN on edge where i_en=1 and active period!=0; same edge: cnt<=0, pulses<=0, o_pwm<=(high!=0).
REQ-018 RUN: cnt increments each cycle; at cnt==period-1 (wrap) cnt<=0 and pulses<=pulses+1.
REQ-019 RUN: o_pwm SHALL equal (next cnt < active high), registered; high>=period gives constant 1, high==0 constant 0.
REQ-020 Staged config SHALL become active only at a wrap edge; i_load on the wrap edge itself SHALL commit the new inputs directly.
REQ-021 RUN->DONE on wrap where times!=0 and pulses+1==times; same edge o_pwm<=0, o_done<=1 for one cycle.
REQ-022 DONE: o_pwm=0; DONE->IDLE when i_en=0; no restart while i_en stays 1.
REQ-023 i_en=0 in RUN SHALL force IDLE next edge, o_pwm<=0, no o_done.
REQ-024 Committed period==0 in RUN SHALL force IDLE, o_pwm<=0, no o_done.
REQ-025 Channels SHALL be fully independent; no cross-channel timing dependency.
REQ-026 Counter arithmetic SHALL be unsigned CNT_W bits; pulse counter TIMES_W bits, no overflow in continuous mode (wraps silently).

Reset
REQ-027 rst=1 SHALL set all FSMs IDLE, cnt/pulses 0, staged and active configs 0, o_pwm=0, o_busy=0, o_done=0.
REQ-028 rst SHALL override i_en and i_load on the same edge; reset mid-burst produces no o_done.

Configuration
REQ-029 Macro PWM_MULTI_POLARITY_EN SHALL control output polarity support.
REQ-030 With PWM_MULTI_POLARITY_EN defined: extra input i_pol (CHANNELS, staged/committed like other fields); o_pwm[n] = raw ^ active pol[n], including IDLE/DONE idle level; reset pol=0.
REQ-031 Without it: no i_pol port; outputs active-high, idle level 0.

Verification
REQ-032 ch0 period=8 high=5 times=3, i_en rises -> o_pwm 5 high/3 low x3, o_done pulse on cycle 24 after start, o_busy 24 cycles.
REQ-033 ch1 period=100 high=40 times=0 -> continuous 40/60 pattern for 1000 cycles, o_done never asserted.
REQ-034 ch0 running period=8 high=5, i_load period=10 high=2 at cnt=3 -> current period stays 8/5, next period 10 cycles with 2 high.
REQ-035 ch2 i_en dropped at cycle 50 of 80-cycle burst -> o_pwm=0 next edge, no o_done; re-enable restarts with cnt=0.
REQ-036 Boundaries: high=0 -> o_pwm constant 0; high=12 period=8 -> constant 1; period=0 -> stays IDLE, o_busy=0.
REQ-037 With PWM_MULTI_POLARITY_EN, i_pol=1, period=8 high=5 -> 5 low/3 high, idle level 1; rst mid-run -> all outputs to reset values.
